// File: rtl/timer_defs.sv
// Register map and bit positions shared by the interval timer RTL.
package timer_defs;

  typedef enum logic [1:0] {
    REG_CTRL   = 2'd0,
    REG_RELOAD = 2'd1,
    REG_COUNT  = 2'd2,
    REG_STATUS = 2'd3
  } reg_sel_e;

  localparam int CTRL_EN   = 0;
  localparam int CTRL_AUTO = 1;
  localparam int CTRL_IE   = 2;

  localparam int STATUS_PEND    = 0;
  localparam int STATUS_PRE_LSB = 8;

  typedef struct packed {
    logic ie;
    logic auto_rl;
    logic en;
  } ctrl_t;

  function automatic logic [31:0] merge_lanes(
    input logic [31:0] old_v,
    input logic [31:0] new_v,
    input logic [3:0]  sel
  );
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/interval_timer_prescaler.sv
// Tick divider for the interval timer; built only when
// INTERVAL_TIMER_PRESCALER_EN is defined.
`ifdef INTERVAL_TIMER_PRESCALER_EN
module interval_timer_prescaler (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       en_i,
  input  logic       clear_i,
  input  logic [7:0] prescale_i,
  output logic       tick_o
);

  logic [7:0] div;

  assign tick_o = en_i & ~clear_i & (div == prescale_i);

  always_ff @(posedge clock_i) begin
    if (reset_i || clear_i) begin
      div <= '0;
    end else if (en_i) begin
      div <= (div == prescale_i) ? 8'd0 : div + 8'd1;
    end
  end

endmodule
`endif

// File: rtl/interval_timer.sv
// Memory-mapped down-counting interval timer with level interrupt.
// Optional tick prescaler: define INTERVAL_TIMER_PRESCALER_EN.
module interval_timer
  import timer_defs::*;
#(
  parameter int COUNT_WIDTH  = 32,
  parameter int RESET_RELOAD = 50
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic [3:0]  addr_i,
  input  logic        read_i,
  input  logic        write_i,
  input  logic [3:0]  sel_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        ready_o,
  output logic        interrupt_request_o
);

  localparam logic [COUNT_WIDTH-1:0] RST_VAL =
    COUNT_WIDTH'(RESET_RELOAD);
  localparam logic [COUNT_WIDTH-1:0] ONE = COUNT_WIDTH'(1);

  ctrl_t                  ctrl;
  ctrl_t                  ctrl_nxt;
  logic                   pend;
  logic [COUNT_WIDTH-1:0] reload;
  logic [COUNT_WIDTH-1:0] count;
  logic [COUNT_WIDTH-1:0] reload_nxt;
  logic [COUNT_WIDTH-1:0] count_nxt;
  logic [7:0]             prescale;

  reg_sel_e    rsel;
  logic        accept;
  logic        wr;
  logic        rd;
  logic        wr_ctrl;
  logic        wr_reload;
  logic        wr_count;
  logic        wr_status;
  logic        w1c;
  logic        en_eff;
  logic        tick;
  logic        terminal;
  logic [31:0] ctrl32;
  logic [31:0] reload32;
  logic [31:0] count32;
  logic [31:0] status32;
  logic [31:0] rdata;
  logic        unused;

  assign unused = ^addr_i[1:0];

  // No new access is taken while the previous one is completing.
  assign rsel   = reg_sel_e'(addr_i[3:2]);
  assign accept = (read_i | write_i) & ~ready_o;
  assign wr     = accept & write_i;
  assign rd     = accept & read_i & ~write_i;

  assign wr_ctrl   = wr & (rsel == REG_CTRL);
  assign wr_reload = wr & (rsel == REG_RELOAD);
  assign wr_count  = wr & (rsel == REG_COUNT);
  assign wr_status = wr & (rsel == REG_STATUS);

  always_comb begin
    ctrl32   = '0;
    ctrl32[2:0] = ctrl;
    reload32 = '0;
    reload32[COUNT_WIDTH-1:0] = reload;
    count32  = '0;
    count32[COUNT_WIDTH-1:0] = count;
    status32 = '0;
    status32[STATUS_PEND] = pend;
    status32[STATUS_PRE_LSB +: 8] = prescale;
  end

  assign ctrl_nxt =
    ctrl_t'(3'(merge_lanes(ctrl32, data_i, sel_i)));
  assign reload_nxt =
    COUNT_WIDTH'(merge_lanes(reload32, data_i, sel_i));
  assign count_nxt =
    COUNT_WIDTH'(merge_lanes(count32, data_i, sel_i));

  always_comb begin
    rdata = '0;
    unique case (rsel)
      REG_CTRL:   rdata = ctrl32;
      REG_RELOAD: rdata = reload32;
      REG_COUNT:  rdata = count32;
      REG_STATUS: rdata = status32;
      default:    rdata = '0;
    endcase
  end

  assign w1c = wr_status & sel_i[0] & data_i[STATUS_PEND];

  // A disabling CTRL write suppresses the tick in its own cycle.
  assign en_eff = ctrl.en & ~(wr_ctrl & ~ctrl_nxt.en);

`ifdef INTERVAL_TIMER_PRESCALER_EN
  logic pre_tick;
  logic pre_clear;

  assign pre_clear = (wr_ctrl & ctrl_nxt.en & ~ctrl.en)
                   | (wr_status & sel_i[1]);

  interval_timer_prescaler u_prescaler (
    .clock_i    (clock_i),
    .reset_i    (reset_i),
    .en_i       (en_eff),
    .clear_i    (pre_clear),
    .prescale_i (prescale),
    .tick_o     (pre_tick)
  );

  assign tick = en_eff & pre_tick;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      prescale <= '0;
    end else if (wr_status && sel_i[1]) begin
      prescale <= data_i[15:8];
    end
  end
`else
  assign prescale = '0;
  assign tick     = en_eff;
`endif

  assign terminal = tick & (count == '0);

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      ctrl                <= '0;
      reload              <= RST_VAL;
      count               <= RST_VAL;
      pend                <= 1'b0;
      ready_o             <= 1'b0;
      data_o              <= '0;
      interrupt_request_o <= 1'b0;
    end else begin
      ready_o             <= accept;
      data_o              <= rd ? rdata : '0;
      interrupt_request_o <= pend & ctrl.ie;
      if (tick) begin
        if (count == '0) begin
          pend <= 1'b1;
          if (ctrl.auto_rl) count <= reload;
          else ctrl.en <= 1'b0;
        end else begin
          count <= count - ONE;
        end
      end
      // Terminal count beats a same-cycle clear; writes beat ticks.
      if (w1c && !terminal) pend <= 1'b0;
      if (wr_ctrl) ctrl <= ctrl_nxt;
      if (wr_reload) reload <= reload_nxt;
      if (wr_count) count <= count_nxt;
    end
  end

endmodule

// File: tb/tb_interval_timer.sv
// Self-checking bench for interval_timer; expectations come from
// closed-form timing of the register/tick rules.
module tb_interval_timer;

  logic        clock_i = 1'b0;
  logic        reset_i = 1'b1;
  logic [3:0]  addr_i  = '0;
  logic        read_i  = 1'b0;
  logic        write_i = 1'b0;
  logic [3:0]  sel_i   = '0;
  logic [31:0] data_i  = '0;
  logic [31:0] data_o;
  logic        ready_o;
  logic        interrupt_request_o;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  interval_timer dut (
    .clock_i             (clock_i),
    .reset_i             (reset_i),
    .addr_i              (addr_i),
    .read_i              (read_i),
    .write_i             (write_i),
    .sel_i               (sel_i),
    .data_i              (data_i),
    .data_o              (data_o),
    .ready_o             (ready_o),
    .interrupt_request_o (interrupt_request_o)
  );

  always #5 clock_i = ~clock_i;
  always @(posedge clock_i) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d,
                           input logic [3:0] s, output int c);
    @(negedge clock_i);
    addr_i = a; data_i = d; sel_i = s; write_i = 1'b1; read_i = 1'b0;
    @(posedge clock_i); #1;
    c = cyc;
    checks++;
    if (ready_o !== 1'b1) begin
      errors++;
      $display("FAIL wr_ready addr=%h got=%b exp=1", a, ready_o);
    end
    @(posedge clock_i); #1;
    checks++;
    if (ready_o !== 1'b0) begin
      errors++;
      $display("FAIL wr_ready_pulse addr=%h got=%b exp=0", a, ready_o);
    end
    write_i = 1'b0;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d,
                          output int c);
    @(negedge clock_i);
    addr_i = a; read_i = 1'b1; write_i = 1'b0;
    @(posedge clock_i); #1;
    c = cyc;
    d = data_o;
    checks++;
    if (ready_o !== 1'b1) begin
      errors++;
      $display("FAIL rd_ready addr=%h got=%b exp=1", a, ready_o);
    end
    @(posedge clock_i); #1;
    checks++;
    if (ready_o !== 1'b0) begin
      errors++;
      $display("FAIL rd_ready_pulse addr=%h got=%b exp=0", a, ready_o);
    end
    read_i = 1'b0;
  endtask

  task automatic wait_irq(input int limit, output int at);
    at = -1;
    for (int i = 0; i < limit; i++) begin
      if (interrupt_request_o === 1'b1) begin
        at = cyc;
        break;
      end
      @(posedge clock_i); #1;
    end
  endtask

  task automatic test_reset;
    logic [31:0] v;
    logic [31:0] exp_v [4];
    int c;
    exp_v = '{32'd0, 32'd50, 32'd50, 32'd0};
    reset_i = 1'b1;
    repeat (3) @(posedge clock_i);
    #1;
    checks++;
    if (ready_o !== 1'b0 || data_o !== 32'd0 ||
        interrupt_request_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_out got rdy=%b d=%h irq=%b exp 0/0/0",
               ready_o, data_o, interrupt_request_o);
    end
    @(negedge clock_i);
    reset_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus_read(4'(i * 4), v, c);
      checks++;
      if (v !== exp_v[i]) begin
        errors++;
        $display("FAIL reset_reg%0d got=%h exp=%h", i, v, exp_v[i]);
      end
    end
  endtask

  task automatic test_periodic;
    int r, c, ca, at;
    r = $urandom_range(2, 6);
    bus_write(4'h4, r, 4'hF, c);
    bus_write(4'h8, r, 4'hF, c);
    bus_write(4'h0, 32'd7, 4'hF, ca);
    wait_irq(30, at);
    checks++;
    if (at != ca + r + 2) begin
      errors++;
      $display("FAIL periodic_first R=%0d got=%0d exp=%0d", r, at, ca + r + 2);
    end
    bus_write(4'hC, 32'd1, 4'h1, c);
    checks++;
    if (interrupt_request_o !== 1'b0) begin
      errors++;
      $display("FAIL periodic_clear got=%b exp=0", interrupt_request_o);
    end
    wait_irq(30, at);
    checks++;
    if (at != ca + 2 * r + 3) begin
      errors++;
      $display("FAIL periodic_repeat R=%0d got=%0d exp=%0d",
               r, at, ca + 2 * r + 3);
    end
    bus_write(4'h0, 32'd0, 4'hF, c);
    bus_write(4'hC, 32'd1, 4'h1, c);
  endtask

  task automatic test_back_to_back;
    int c, ce, cz, cw, cr, n;
    logic [31:0] v, v0, exp_v;
    v0 = $urandom_range(100, 1000);
    n  = $urandom_range(0, 5);
    bus_write(4'h8, v0, 4'hF, c);
    bus_write(4'h0, 32'd1, 4'hF, ce);
    repeat (n) @(posedge clock_i);
    bus_write(4'h0, 32'd0, 4'hF, cz);
    bus_read(4'h8, v, c);
    exp_v = v0 - 32'(cz - 1 - ce);
    checks++;
    if (v !== exp_v) begin
      errors++;
      $display("FAIL disable_race got=%0d exp=%0d", v, exp_v);
    end
    v0 = $urandom_range(100, 1000);
    bus_write(4'h0, 32'd1, 4'hF, c);
    bus_write(4'h8, v0, 4'hF, cw);
    bus_read(4'h8, v, cr);
    exp_v = v0 - 32'(cr - 1 - cw);
    checks++;
    if (v !== exp_v) begin
      errors++;
      $display("FAIL count_write_race got=%0d exp=%0d", v, exp_v);
    end
    bus_write(4'h0, 32'd0, 4'hF, c);
  endtask

  task automatic test_oneshot;
    int k, c, ca, at;
    logic [31:0] v;
    k = $urandom_range(1, 5);
    bus_write(4'h8, k, 4'hF, c);
    bus_write(4'h0, 32'd5, 4'hF, ca);
    wait_irq(30, at);
    checks++;
    if (at != ca + k + 2) begin
      errors++;
      $display("FAIL oneshot_irq K=%0d got=%0d exp=%0d", k, at, ca + k + 2);
    end
    bus_read(4'h0, v, c);
    checks++;
    if (v !== 32'd4) begin
      errors++;
      $display("FAIL oneshot_ctrl got=%h exp=4", v);
    end
    bus_read(4'h8, v, c);
    checks++;
    if (v !== 32'd0) begin
      errors++;
      $display("FAIL oneshot_count got=%h exp=0", v);
    end
    bus_read(4'hC, v, c);
    checks++;
    if (v !== 32'd1) begin
      errors++;
      $display("FAIL oneshot_pend got=%h exp=1", v);
    end
    bus_write(4'hC, 32'd1, 4'h1, c);
    repeat (10) @(posedge clock_i);
    #1;
    checks++;
    if (interrupt_request_o !== 1'b0) begin
      errors++;
      $display("FAIL oneshot_single got=%b exp=0", interrupt_request_o);
    end
    bus_read(4'hC, v, c);
    checks++;
    if (v !== 32'd0) begin
      errors++;
      $display("FAIL oneshot_status got=%h exp=0", v);
    end
    bus_write(4'h0, 32'd0, 4'hF, c);
  endtask

  task automatic test_w1c_race;
    int r, c, ca, tgt;
    logic [31:0] v;
    r = $urandom_range(2, 6);
    bus_write(4'h4, r, 4'hF, c);
    bus_write(4'h8, r, 4'hF, c);
    bus_write(4'h0, 32'd7, 4'hF, ca);
    tgt = ca + r + 1;
    while (cyc < tgt - 1) begin
      @(posedge clock_i); #1;
    end
    bus_write(4'hC, 32'd1, 4'h1, c);
    checks++;
    if (interrupt_request_o !== 1'b1) begin
      errors++;
      $display("FAIL w1c_race_irq got=%b exp=1", interrupt_request_o);
    end
    bus_read(4'hC, v, c);
    checks++;
    if (v !== 32'd1) begin
      errors++;
      $display("FAIL w1c_race_pend got=%h exp=1", v);
    end
    bus_write(4'h0, 32'd0, 4'hF, c);
    bus_write(4'hC, 32'd1, 4'h1, c);
  endtask

  task automatic test_byte_write;
    int c;
    logic [31:0] v, o, d, exp_v, x;
    logic [3:0] s;
    bus_write(4'h4, 32'h11223344, 4'hF, c);
    bus_write(4'h4, 32'h0000AB00, 4'b0010, c);
    bus_read(4'h4, v, c);
    checks++;
    if (v !== 32'h1122AB44) begin
      errors++;
      $display("FAIL byte_fixed got=%h exp=1122ab44", v);
    end
    for (int i = 0; i < 4; i++) begin
      o = $urandom;
      d = $urandom;
      s = 4'($urandom_range(0, 15));
      exp_v = o;
      for (int b = 0; b < 4; b++)
        if (s[b]) exp_v[b*8 +: 8] = d[b*8 +: 8];
      bus_write(4'h4, o, 4'hF, c);
      bus_write(4'h4, d, s, c);
      bus_read(4'h4, v, c);
      checks++;
      if (v !== exp_v) begin
        errors++;
        $display("FAIL byte_rand sel=%b got=%h exp=%h", s, v, exp_v);
      end
    end
    x = $urandom;
    @(negedge clock_i);
    addr_i = 4'h4; data_i = x; sel_i = 4'hF;
    read_i = 1'b1; write_i = 1'b1;
    @(posedge clock_i); #1;
    checks++;
    if (ready_o !== 1'b1 || data_o !== 32'd0) begin
      errors++;
      $display("FAIL rdwr_both got rdy=%b d=%h exp 1/0", ready_o, data_o);
    end
    @(posedge clock_i); #1;
    read_i = 1'b0; write_i = 1'b0;
    bus_read(4'h4, v, c);
    checks++;
    if (v !== x) begin
      errors++;
      $display("FAIL rdwr_commit got=%h exp=%h", v, x);
    end
    bus_write(4'hC, 32'h0000FF00, 4'b0010, c);
    bus_read(4'hC, v, c);
`ifdef INTERVAL_TIMER_PRESCALER_EN
    exp_v = 32'h0000FF00;
`else
    exp_v = 32'h0;
`endif
    checks++;
    if (v !== exp_v) begin
      errors++;
      $display("FAIL prescale_field got=%h exp=%h", v, exp_v);
    end
    bus_write(4'hC, 32'h0, 4'b0010, c);
  endtask

  task automatic test_prescale;
    int c, ca, at, lat;
    bus_write(4'h8, 32'd1, 4'hF, c);
`ifdef INTERVAL_TIMER_PRESCALER_EN
    bus_write(4'hC, 32'h00000300, 4'b0010, c);
    lat = 8;
`else
    lat = 2;
`endif
    bus_write(4'h0, 32'd5, 4'hF, ca);
    wait_irq(40, at);
    checks++;
    if (at != ca + lat + 1) begin
      errors++;
      $display("FAIL prescale_latency got=%0d exp=%0d", at, ca + lat + 1);
    end
    bus_write(4'h0, 32'd0, 4'hF, c);
    bus_write(4'hC, 32'd1, 4'h3, c);
  endtask

  task automatic test_reset_mid;
    int c;
    logic [31:0] v;
    bus_write(4'h4, 32'h1234, 4'hF, c);
    bus_write(4'h0, 32'd6, 4'hF, c);
    @(negedge clock_i);
    addr_i = 4'h4; read_i = 1'b1; reset_i = 1'b1;
    @(posedge clock_i); #1;
    checks++;
    if (ready_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_ready got=%b exp=0", ready_o);
    end
    @(negedge clock_i);
    read_i = 1'b0; reset_i = 1'b0;
    bus_read(4'h4, v, c);
    checks++;
    if (v !== 32'd50) begin
      errors++;
      $display("FAIL reset_mid_reload got=%h exp=32", v);
    end
    bus_read(4'h0, v, c);
    checks++;
    if (v !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid_ctrl got=%h exp=0", v);
    end
  endtask

  initial begin
    test_reset;
    test_periodic;
    test_back_to_back;
    test_oneshot;
    test_w1c_race;
    test_byte_write;
    test_prescale;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
